// File: rtl/rf_cfg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_cfg_sequencer: quiesces the RF frontend, applies a new configuration, |
// | streams FIR coefficients from a shadow RAM and re-enables stages in order. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rf_cfg_sequencer #(
  parameter int NCO_WIDTH      = 24,
  parameter int COEFF_WIDTH    = 18,
  parameter int FIR_TAPS       = 64,
  parameter int CIC_DECIMATION = 8,
  parameter int FIR_DECIMATION = 4,
  parameter int DRAIN_CYCLES   = 16,
  parameter int LOCK_TIMEOUT   = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [NCO_WIDTH-1:0]   cfg_nco_freq,
  input  logic [7:0]             cfg_cic_dec,
  input  logic [7:0]             cfg_fir_dec,
  input  logic                   cfg_load_coeffs,
  input  logic                   host_coeff_wr,
  input  logic [7:0]             host_coeff_addr,
  input  logic [COEFF_WIDTH-1:0] host_coeff_data,
  output logic [NCO_WIDTH-1:0]   nco_freq,
  output logic [7:0]             cic_decimation,
  output logic [7:0]             fir_decimation,
  output logic [COEFF_WIDTH-1:0] fir_coeff_data,
  output logic [7:0]             fir_coeff_addr,
  output logic                   fir_coeff_wr,
  output logic                   fir_coeff_ld,
  output logic                   enable_ddc,
  output logic                   enable_fir,
  output logic                   enable_decimation,
  input  logic                   ddc_locked,
  output logic                   busy,
  output logic                   done,
  output logic                   lock_err,
  output logic [3:0]             seq_state
);

  localparam int ADDR_W  = (FIR_TAPS > 1) ? $clog2(FIR_TAPS) : 1;
  localparam int CNT_MAX = (DRAIN_CYCLES > LOCK_TIMEOUT) ? DRAIN_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [8:0]       TAPS       = 9'(FIR_TAPS);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_DRAIN  = 4'd1,
    S_APPLY  = 4'd2,
    S_CW_WR  = 4'd3,
    S_CW_GAP = 4'd4,
    S_CW_LD  = 4'd5,
    S_EN_DDC = 4'd6,
    S_EN_FIR = 4'd7,
    S_EN_DEC = 4'd8
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [8:0]             idx;
  logic [8:0]             idx_next;
  logic [NCO_WIDTH-1:0]   lat_nco;
  logic [7:0]             lat_cic;
  logic [7:0]             lat_fir;
  logic                   lat_load;
  logic                   host_in_range;
  logic [COEFF_WIDTH-1:0] shadow [FIR_TAPS];

  assign idx_next      = idx + 9'd1;
  assign host_in_range = ({1'b0, host_coeff_addr} < TAPS);
  assign cfg_ready     = (state == S_IDLE);
  assign seq_state     = state;

  // Shadow RAM is not reset so host-loaded coefficients survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (host_coeff_wr && host_in_range) begin
      shadow[host_coeff_addr[ADDR_W-1:0]] <= host_coeff_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      cnt               <= '0;
      idx               <= '0;
      lat_nco           <= '0;
      lat_cic           <= 8'(CIC_DECIMATION);
      lat_fir           <= 8'(FIR_DECIMATION);
      lat_load          <= 1'b0;
      nco_freq          <= '0;
      cic_decimation    <= 8'(CIC_DECIMATION);
      fir_decimation    <= 8'(FIR_DECIMATION);
      fir_coeff_data    <= '0;
      fir_coeff_addr    <= '0;
      fir_coeff_wr      <= 1'b0;
      fir_coeff_ld      <= 1'b0;
      enable_ddc        <= 1'b0;
      enable_fir        <= 1'b0;
      enable_decimation <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      lock_err          <= 1'b0;
    end else begin
      done         <= 1'b0;
      fir_coeff_wr <= 1'b0;
      fir_coeff_ld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            lat_nco           <= cfg_nco_freq;
            lat_cic           <= cfg_cic_dec;
            lat_fir           <= cfg_fir_dec;
            lat_load          <= cfg_load_coeffs;
            lock_err          <= 1'b0;
            enable_ddc        <= 1'b0;
            enable_fir        <= 1'b0;
            enable_decimation <= 1'b0;
            busy              <= 1'b1;
            cnt               <= '0;
            state             <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            nco_freq       <= lat_nco;
            cic_decimation <= lat_cic;
            fir_decimation <= lat_fir;
            state          <= S_APPLY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_APPLY: begin
          idx <= '0;
          cnt <= '0;
          if (lat_load) begin
            fir_coeff_wr   <= 1'b1;
            fir_coeff_addr <= '0;
            fir_coeff_data <= shadow[{ADDR_W{1'b0}}];
            state          <= S_CW_WR;
          end else begin
            enable_ddc <= 1'b1;
            state      <= S_EN_DDC;
          end
        end
        S_CW_WR: begin
          state <= S_CW_GAP;
        end
        S_CW_GAP: begin
          idx <= idx_next;
          if (idx_next == TAPS) begin
            fir_coeff_ld <= 1'b1;
            state        <= S_CW_LD;
          end else begin
            // Read-first: a same-cycle host write to this address lands after the read.
            fir_coeff_wr   <= 1'b1;
            fir_coeff_addr <= idx_next[7:0];
            fir_coeff_data <= shadow[idx_next[ADDR_W-1:0]];
            state          <= S_CW_WR;
          end
        end
        S_CW_LD: begin
          enable_ddc <= 1'b1;
          cnt        <= '0;
          state      <= S_EN_DDC;
        end
        S_EN_DDC: begin
          if (ddc_locked) begin
            enable_fir <= 1'b1;
            state      <= S_EN_FIR;
          end else if (cnt == LOCK_LAST) begin
            lock_err <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EN_FIR: begin
          enable_decimation <= 1'b1;
          done              <= 1'b1;
          state             <= S_EN_DEC;
        end
        S_EN_DEC: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_cfg_sequencer.sv
`default_nettype none
// tb_rf_cfg_sequencer: directed and randomized checks of rf_cfg_sequencer against a
// cycle-offset behavioural model (offsets measured from the request accept edge).
module tb_rf_cfg_sequencer;
  localparam int D  = 16;
  localparam int T  = 64;
  localparam int LT = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_nco_freq;
  logic [7:0]  cfg_cic_dec;
  logic [7:0]  cfg_fir_dec;
  logic        cfg_load_coeffs;
  logic        host_coeff_wr;
  logic [7:0]  host_coeff_addr;
  logic [17:0] host_coeff_data;
  logic [23:0] nco_freq;
  logic [7:0]  cic_decimation;
  logic [7:0]  fir_decimation;
  logic [17:0] fir_coeff_data;
  logic [7:0]  fir_coeff_addr;
  logic        fir_coeff_wr;
  logic        fir_coeff_ld;
  logic        enable_ddc;
  logic        enable_fir;
  logic        enable_decimation;
  logic        ddc_locked;
  logic        busy;
  logic        done;
  logic        lock_err;
  logic [3:0]  seq_state;

  always #5 clk = ~clk;

  rf_cfg_sequencer #(
    .NCO_WIDTH(24), .COEFF_WIDTH(18), .FIR_TAPS(T), .CIC_DECIMATION(8),
    .FIR_DECIMATION(4), .DRAIN_CYCLES(D), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_nco_freq(cfg_nco_freq), .cfg_cic_dec(cfg_cic_dec), .cfg_fir_dec(cfg_fir_dec),
    .cfg_load_coeffs(cfg_load_coeffs), .host_coeff_wr(host_coeff_wr),
    .host_coeff_addr(host_coeff_addr), .host_coeff_data(host_coeff_data),
    .nco_freq(nco_freq), .cic_decimation(cic_decimation), .fir_decimation(fir_decimation),
    .fir_coeff_data(fir_coeff_data), .fir_coeff_addr(fir_coeff_addr),
    .fir_coeff_wr(fir_coeff_wr), .fir_coeff_ld(fir_coeff_ld), .enable_ddc(enable_ddc),
    .enable_fir(enable_fir), .enable_decimation(enable_decimation), .ddc_locked(ddc_locked),
    .busy(busy), .done(done), .lock_err(lock_err), .seq_state(seq_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_seen;
  int ld_cyc;
  int lock_mode;
  bit rand_wr_en;
  logic [17:0] cap [64];

  // model state
  logic [17:0] sh [64];
  bit          m_act;
  int          m_pos;
  bit          m_load;
  int          m_ddc;
  int          m_fir_at;
  logic [23:0] m_lnco;
  logic [7:0]  m_lcic, m_lfir;
  logic [23:0] e_nco;
  logic [7:0]  e_cic, e_fir, e_addr;
  logic [17:0] e_data;
  logic        e_en_ddc, e_en_fir, e_en_dec, e_wr, e_ld, e_done, e_busy, e_lock_err;
  logic [3:0]  e_state;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_pos = 0; m_fir_at = -1;
    e_nco = '0; e_cic = 8'd8; e_fir = 8'd4; e_addr = '0; e_data = '0;
    e_en_ddc = 0; e_en_fir = 0; e_en_dec = 0; e_wr = 0; e_ld = 0;
    e_done = 0; e_busy = 0; e_lock_err = 0; e_state = 4'd0;
  endtask

  // Expected outputs for the cycle following this edge, from the offset since accept.
  task automatic model_step();
    int cur, n, off;
    e_done = 0; e_wr = 0; e_ld = 0;
    if (!m_act && cfg_valid) begin
      m_act = 1; m_pos = 0; m_fir_at = -1;
      m_lnco = cfg_nco_freq; m_lcic = cfg_cic_dec; m_lfir = cfg_fir_dec;
      m_load = cfg_load_coeffs;
      e_lock_err = 0; e_en_ddc = 0; e_en_fir = 0; e_en_dec = 0;
      m_ddc = D + 2 + (m_load ? 2 * T + 1 : 0);
    end
    if (m_act) begin
      cur = m_pos; n = cur + 1; off = n - (D + 2);
      if (cur >= m_ddc && m_fir_at < 0) begin
        if (ddc_locked) m_fir_at = n;
        else if (cur - m_ddc == LT - 1) begin
          m_act = 0; e_done = 1; e_lock_err = 1;
        end
      end
      if (m_act && m_fir_at >= 0 && cur == m_fir_at + 1) m_act = 0;
      if (m_act) begin
        if (n == D + 1) begin e_nco = m_lnco; e_cic = m_lcic; e_fir = m_lfir; end
        if (m_load && off >= 0 && off < 2 * T && off % 2 == 0) begin
          e_wr = 1; e_addr = 8'(off / 2); e_data = sh[off / 2];
        end
        if (m_load && off == 2 * T) e_ld = 1;
        if (n == m_ddc) e_en_ddc = 1;
        if (n == m_fir_at) e_en_fir = 1;
        if (m_fir_at >= 0 && n == m_fir_at + 1) begin e_en_dec = 1; e_done = 1; end
        if (n <= D) e_state = 4'd1;
        else if (n == D + 1) e_state = 4'd2;
        else if (n < m_ddc) e_state = (off == 2 * T) ? 4'd5 : ((off % 2 == 0) ? 4'd3 : 4'd4);
        else if (m_fir_at < 0 || n < m_fir_at) e_state = 4'd6;
        else if (n == m_fir_at) e_state = 4'd7;
        else e_state = 4'd8;
        m_pos = n;
      end
    end
    e_busy = m_act;
    if (!m_act) e_state = 4'd0;
  endtask

  task automatic drive_random();
    if (rand_wr_en) begin
      host_coeff_wr   = ($urandom_range(0, 3) == 0);
      host_coeff_addr = 8'($urandom_range(0, 79));
      host_coeff_data = 18'($urandom);
    end
    case (lock_mode)
      0: ddc_locked = 1'b1;
      1: ddc_locked = 1'b0;
      default: ddc_locked = ($urandom_range(0, 7) == 0);
    endcase
  endtask

  task automatic compare_all();
    logic [127:0] act, exp;
    act = 128'({cfg_ready, busy, done, lock_err, seq_state, enable_ddc, enable_fir,
                enable_decimation, fir_coeff_wr, fir_coeff_ld, fir_coeff_addr,
                fir_coeff_data, nco_freq, cic_decimation, fir_decimation});
    exp = 128'({(e_state == 4'd0), e_busy, e_done, e_lock_err, e_state, e_en_ddc, e_en_fir,
                e_en_dec, e_wr, e_ld, e_addr, e_data, e_nco, e_cic, e_fir});
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, act, exp);
    end
    if (bad > 40) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  // One clock: model update at the edge, drive at +1, sample and compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset(); else model_step();
    if (host_coeff_wr && host_coeff_addr < 8'd64) sh[host_coeff_addr[5:0]] = host_coeff_data;
    #1;
    drive_random();
    @(negedge clk);
    if (fir_coeff_wr) begin wr_seen++; cap[fir_coeff_addr[5:0]] = fir_coeff_data; end
    if (fir_coeff_ld) ld_cyc = cyc;
    compare_all();
  endtask

  task automatic request(input logic [23:0] nco, input logic [7:0] cic, input logic [7:0] fir,
                         input bit ld, input bit hold, output int acc);
    cfg_nco_freq = nco; cfg_cic_dec = cic; cfg_fir_dec = fir; cfg_load_coeffs = ld;
    cfg_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 3000 && acc < 0; i++) begin
      if (cfg_ready) acc = cyc;
      tick();
    end
    if (acc < 0) chk("accept_timeout", 0, 1);
    if (!hold) cfg_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 3000 && dc < 0; i++) begin
      if (done) dc = cyc; else tick();
    end
    if (dc < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int acc, dc, dc2;
    bit found;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_nco_freq = '0; cfg_cic_dec = '0; cfg_fir_dec = '0;
    cfg_load_coeffs = 1'b0; host_coeff_wr = 1'b0; host_coeff_addr = '0; host_coeff_data = '0;
    ddc_locked = 1'b1; lock_mode = 0; rand_wr_en = 0; wr_seen = 0; ld_cyc = -1;
    for (int i = 0; i < 64; i++) begin sh[i] = '0; cap[i] = '0; end
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_cic", 32'(cic_decimation), 8);
    chk("rst_fir", 32'(fir_decimation), 4);
    chk("rst_en", {enable_ddc, enable_fir, enable_decimation}, 0);
    chk("rst_ready", 32'(cfg_ready), 1);

    for (int a = 0; a < 64; a++) begin
      host_coeff_wr = 1'b1; host_coeff_addr = 8'(a);
      host_coeff_data = (a < 16) ? 18'h10000 : ((a < 32) ? 18'h08000 : 18'h0);
      tick();
    end
    host_coeff_addr = 8'd70; host_coeff_data = 18'h3ffff;
    tick();
    host_coeff_wr = 1'b0;
    tick();

    // plain reconfiguration, no coefficient load, lock already present
    wr_seen = 0;
    request(24'h100000, 8'd8, 8'd4, 1'b0, 1'b0, acc);
    while (cyc < acc + 16) tick();
    chk("nco_before_apply", nco_freq, 0);
    tick();
    chk("nco_at_apply", nco_freq, 24'h100000);
    wait_done(dc);
    chk("done_latency", dc - acc, 20);
    chk("en_dec_with_done", 32'(enable_decimation), 1);
    chk("no_wr_activity", wr_seen, 0);

    // coefficient reload
    wr_seen = 0; ld_cyc = -1;
    request(24'h0abcde, 8'd16, 8'd2, 1'b1, 1'b0, acc);
    chk("enables_drop", {enable_ddc, enable_fir, enable_decimation}, 0);
    wait_done(dc);
    chk("wr_count", wr_seen, 64);
    chk("ld_offset", ld_cyc - acc, 146);
    chk("done_load_latency", dc - acc, 149);
    chk("coeff5", 32'(cap[5]), 32'h10000);
    chk("coeff6_oob_dropped", 32'(cap[6]), 32'h10000);
    chk("coeff20", 32'(cap[20]), 32'h08000);
    chk("coeff40", 32'(cap[40]), 0);

    // lock timeout
    lock_mode = 1;
    tick();
    request(24'h123456, 8'd4, 8'd8, 1'b0, 1'b0, acc);
    wait_done(dc);
    chk("timeout_latency", dc - acc, 18 + LT);
    chk("timeout_lock_err", 32'(lock_err), 1);
    chk("timeout_en", {enable_ddc, enable_fir, enable_decimation}, 3'b100);

    // cfg_valid held high across a whole sequence
    lock_mode = 0;
    request(24'h000777, 8'd8, 8'd4, 1'b0, 1'b1, acc);
    chk("lock_err_cleared", 32'(lock_err), 0);
    wait_done(dc);
    chk("ready_low_at_done", 32'(cfg_ready), 0);
    tick();
    chk("ready_in_idle", {cfg_ready, busy}, 2'b10);
    tick();
    chk("second_accept", 32'(busy), 1);
    cfg_valid = 1'b0;
    wait_done(dc2);
    chk("second_done", dc2 - dc, 21);

    // reset in the middle of a coefficient stream
    lock_mode = 2; rand_wr_en = 1;
    request(24'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, acc);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (fir_coeff_wr && fir_coeff_addr == 8'd20) found = 1; else tick();
    end
    chk("reached_idx20", 32'(found), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_cfg", {nco_freq, cic_decimation}, {24'h0, 8'd8});
    chk("rst_mid_fir", 32'(fir_decimation), 4);
    chk("rst_mid_coeff", {fir_coeff_wr, fir_coeff_ld, fir_coeff_addr, fir_coeff_data}, 0);
    chk("rst_mid_ctl", {cfg_ready, busy, done, lock_err, seq_state,
                        enable_ddc, enable_fir, enable_decimation}, 11'b100_0000_0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    request(24'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, acc);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (fir_coeff_wr) found = 1; else tick();
    end
    chk("restream_addr", 32'(fir_coeff_addr), 0);
    chk("restream_offset", cyc - acc, 18);
    wait_done(dc);

    // randomized requests with background host writes and random lock timing
    for (int r = 0; r < 6; r++) begin
      request(24'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, acc);
      wait_done(dc);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_wr_en = 0; host_coeff_wr = 1'b0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
